// File: rtl/mc_pkg.sv
// Shared types and widths for the program-memory loader.
// Latency: n/a. Backpressure: n/a.
package mc_pkg;

    localparam int PMEM_AW = 8;
    localparam int INSTR_W = 12;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    function automatic logic rx_state(input state_e s);
        return (s == S_COUNT) || (s == S_HI) || (s == S_LO) || (s == S_CSUM);
    endfunction

    function automatic logic busy_state(input state_e s);
        return rx_state(s) || (s == S_WRITE);
    endfunction

endpackage

// File: rtl/pmem_loader_timeout.sv
// Inter-byte idle watchdog: reloads while not running, counts down while running.
// Latency: expire_o is combinational on the TIMEOUT-th consecutive running cycle.
// Backpressure: none; TIMEOUT=0 disables expiry.
module pmem_loader_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic expire_o
);

    localparam int unsigned RELOAD   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [15:0] RELOAD_V = 16'(RELOAD);

    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!run_i) begin
            cnt_q <= RELOAD_V;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    assign expire_o = (TIMEOUT != 0) && run_i && (cnt_q == '0);

endmodule

// File: rtl/pmem_loader.sv
// Serial byte-stream loader into a 12-bit program memory; optional checksum via PMEM_LOADER_CHECKSUM_EN.
// Latency: one WRITE cycle per word after its LO byte; status registered on the final edge.
// Backpressure: byte_ready is registered from state only (COUNT/HI/LO/CSUM).
module pmem_loader
    import mc_pkg::*;
#(
    parameter logic [PMEM_AW-1:0] BASE_ADDR    = 8'h00,
    parameter int unsigned        IDLE_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [BYTE_W-1:0]  byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               mem_e,
    output logic               load_e,
    output logic [PMEM_AW-1:0] load_addr,
    output logic [INSTR_W-1:0] load_instr,
    output logic               busy,
    output logic               done,
    output logic               error
);

    state_e             state_q, state_d;
    logic [PMEM_AW:0]   idx_q;
    logic [PMEM_AW:0]   n_q;
    logic [3:0]         hi_q;
    logic               byte_ready_q, mem_e_q, load_e_q, busy_q, done_q, error_q;
    logic [PMEM_AW-1:0] load_addr_q;
    logic [INSTR_W-1:0] load_instr_q;
    logic               xfer, expired;
`ifdef PMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  csum_q;
`endif

    assign xfer = byte_valid && byte_ready_q;

    pmem_loader_timeout #(
        .TIMEOUT (IDLE_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_i    (byte_ready_q && !byte_valid),
        .expire_o (expired)
    );

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: if (start) state_d = S_COUNT;
                S_COUNT: begin
                    if (xfer)         state_d = S_HI;
                    else if (expired) state_d = S_ERR;
                end
                S_HI: begin
                    if (xfer)         state_d = (byte_in[7:4] != 4'h0) ? S_ERR : S_LO;
                    else if (expired) state_d = S_ERR;
                end
                S_LO: begin
                    if (xfer)         state_d = S_WRITE;
                    else if (expired) state_d = S_ERR;
                end
                S_WRITE: begin
`ifdef PMEM_LOADER_CHECKSUM_EN
                    state_d = (idx_q + 9'd1 == n_q) ? S_CSUM : S_HI;
`else
                    state_d = (idx_q + 9'd1 == n_q) ? S_DONE : S_HI;
`endif
                end
`ifdef PMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer)         state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
                    else if (expired) state_d = S_ERR;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            n_q          <= '0;
            hi_q         <= '0;
            byte_ready_q <= 1'b0;
            mem_e_q      <= 1'b0;
            load_e_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            load_addr_q  <= '0;
            load_instr_q <= '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mem_e_q      <= 1'b1;
            byte_ready_q <= rx_state(state_d);
            busy_q       <= busy_state(state_d);
            load_e_q     <= (state_d == S_WRITE);
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERR);
            // Abort suppresses every datapath update, including a same-edge LO byte.
            if (!abort) begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (start) begin
                            idx_q  <= '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
                            csum_q <= '0;
`endif
                        end
                    end
                    S_COUNT: if (xfer) n_q <= (byte_in == 8'h00) ? 9'd256 : {1'b0, byte_in};
                    S_HI: begin
                        if (xfer) begin
                            hi_q   <= byte_in[3:0];
`ifdef PMEM_LOADER_CHECKSUM_EN
                            csum_q <= csum_q ^ byte_in;
`endif
                        end
                    end
                    S_LO: begin
                        if (xfer) begin
                            load_instr_q <= {hi_q, byte_in};
                            load_addr_q  <= BASE_ADDR + idx_q[PMEM_AW-1:0];
`ifdef PMEM_LOADER_CHECKSUM_EN
                            csum_q       <= csum_q ^ byte_in;
`endif
                        end
                    end
                    S_WRITE: idx_q <= idx_q + 9'd1;
                    default: ;
                endcase
            end
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_e      = mem_e_q;
    assign load_e     = load_e_q;
    assign load_addr  = load_addr_q;
    assign load_instr = load_instr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Scoreboarded bench for pmem_loader: random and directed loads, abort, timeout, async reset.
module tb_pmem_loader;

    localparam logic [7:0] BASE = 8'hFE;
    localparam int         TO   = 16;
`ifdef PMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_ready, mem_e, load_e, busy, done, error;
    logic [7:0]  load_addr;
    logic [11:0] load_instr;

    pmem_loader #(
        .BASE_ADDR    (BASE),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_e      (mem_e),
        .load_e     (load_e),
        .load_addr  (load_addr),
        .load_instr (load_instr),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [11:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] his[256];
    logic [7:0] los[256];
    int         vectors = 0;
    int         miscompares = 0;
    int         wr_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: every presented write is popped against the model's queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && load_e === 1'b1) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                             load_addr, load_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr_data", {12'h0, load_addr, load_instr}, {12'h0, e.a, e.d});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        int   t;
        r = 1'b0;
        t = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!r && t < 64) begin
            @(negedge clk);
            r = byte_ready;
            @(posedge clk);
            t++;
        end
        #1 byte_valid = 1'b0;
        if (!r) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_status(input string nm, input logic d, input logic e);
        int t;
        t = 0;
        while (!(done || error) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_status"}, {29'h0, busy, done, error}, {29'h0, 1'b0, d, e});
        chk({nm, "_all_writes"}, exp_q.size(), 32'd0);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            his[i] = {4'h0, 4'($urandom)};
            los[i] = 8'($urandom);
        end
    endtask

    // Reference: word i lands at (BASE+i) mod 256; bad HI stops the load; checksum is XOR of HI/LO bytes.
    task automatic run_load(input string nm, input int n, input int bad, input bit csum_bad,
                            input bit poke);
        logic [7:0] x;
        bit         err;
        x   = 8'h00;
        err = (bad >= 0) || (CSUM_ON && csum_bad);
        pulse_start();
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            if (i == bad) begin
                send_byte(his[i]);
                break;
            end
            exp_q.push_back({8'(int'(BASE) + i), his[i][3:0], los[i]});
            if (poke && i == 0) pulse_start();
            send_byte(his[i]);
            idle($urandom_range(0, 2));
            send_byte(los[i]);
            x ^= his[i] ^ los[i];
            idle($urandom_range(0, 2));
        end
`ifdef PMEM_LOADER_CHECKSUM_EN
        if (bad < 0) send_byte(csum_bad ? (x ^ 8'h01) : x);
`endif
        wait_status(nm, !err, err);
    endtask

    initial begin
        int n, bad, w0;
        bit cb, pk;

        #12;
        chk("reset_outputs", {6'h0, byte_ready, mem_e, load_e, busy, done, error, load_addr, load_instr},
            32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        chk("mem_e_after_reset", {31'h0, mem_e}, 32'd1);
        chk("idle_outputs", {27'h0, byte_ready, busy, done, error, load_e}, 32'h0);

        his[0] = 8'h0A; los[0] = 8'hBC; his[1] = 8'h01; los[1] = 8'h23;
        run_load("basic", 2, -1, 1'b0, 1'b0);
        chk("addr_holds", {24'h0, load_addr}, 32'h0000_00FF);
        chk("instr_holds", {20'h0, load_instr}, 32'h0000_0123);
`ifdef PMEM_LOADER_CHECKSUM_EN
        run_load("csum_bad", 2, -1, 1'b1, 1'b0);
`endif

        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_clears_status", {30'h0, done, error}, 32'h0);

        fill_rand(3);
        run_load("wrap3", 3, -1, 1'b0, 1'b0);

        his[0] = 8'h1A; los[0] = 8'h55;
        run_load("bad_hi", 1, 0, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(1, 8);
            fill_rand(n);
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            if (bad >= 0) his[bad][7:4] = 4'($urandom_range(1, 15));
            cb = ($urandom_range(0, 3) == 0);
            pk = ($urandom_range(0, 1) == 1);
            run_load("rand_load", n, bad, cb, pk);
        end

        fill_rand(256);
        run_load("n256", 256, -1, 1'b0, 1'b1);

        w0 = wr_seen;
        pulse_start();
        send_byte(8'd2);
        send_byte(8'h05);
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        abort      = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        abort      = 1'b0;
        chk("abort_in_lo", {27'h0, busy, done, error, byte_ready, load_e}, 32'h0);
        idle(4);
        chk("abort_no_write", wr_seen - w0, 32'd0);

        w0 = wr_seen;
        pulse_start();
        send_byte(8'd1);
        idle(TO - 1);
        send_byte(8'h03);
        chk("timeout_below_limit", {29'h0, busy, done, error}, 32'b100);
        idle(TO - 1);
        chk("timeout_one_short", {29'h0, busy, done, error}, 32'b100);
        idle(1);
        chk("timeout_expired", {29'h0, busy, done, error}, 32'b001);
        chk("timeout_no_write", wr_seen - w0, 32'd0);

        pulse_start();
        send_byte(8'd3);
        fill_rand(1);
        exp_q.push_back({8'(int'(BASE)), his[0][3:0], los[0]});
        send_byte(his[0]);
        send_byte(los[0]);
        @(negedge clk);
        n = 0;
        while (load_e !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reset_test_in_write", {31'h0, load_e}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {6'h0, byte_ready, mem_e, load_e, busy, done, error, load_addr, load_instr}, 32'h0);
        w0 = wr_seen;
        idle(3);
        rst_n = 1'b1;
        idle(6);
        chk("post_reset_idle", {28'h0, busy, done, error, mem_e}, 32'd1);
        chk("post_reset_no_write", wr_seen - w0, 32'd0);
        chk("post_reset_queue", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pmem_loader.md
PMEM_LOADER -- requirements
Module: pmem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00, first program-memory address written.
REQ-002 Parameter IDLE_TIMEOUT, default 255, max cycles to wait for the next byte mid-load (0 = no timeout).
REQ-003 clk  input  1  single clock, all state on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 abort  input  1  cancel any load in progress.
REQ-007 byte_in  input  8  serial program byte stream.
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_e  output  1  program memory enable (E).
REQ-011 load_e  output  1  program memory write enable (LoadE).
REQ-012 load_addr  output  8  program memory write address.
REQ-013 load_instr  output  12  program memory write data.
REQ-014 busy, done, error  output  1 each  load active / last load succeeded / last load failed.

Function
REQ-015 A byte transfers only on a posedge with byte_valid=1 and byte_ready=1; byte_ready is a registered function of state only, never of byte_valid.
REQ-016 States: IDLE, COUNT, HI, LO, WRITE, CSUM, DONE, ERR; byte_ready=1 only in COUNT, HI, LO, CSUM.
REQ-017 IDLE/DONE/ERR + start -> COUNT; clears done and error; index <= 0; running XOR <= 0.
REQ-018 COUNT: accepted byte is word count N (8'h00 means 256) -> HI.
REQ-019 HI: accepted byte b; b[7:4] != 0 -> ERR; else instr[11:8] <= b[3:0] -> LO.
REQ-020 LO: accepted byte -> instr[7:0], -> WRITE.
REQ-021 WRITE lasts exactly one cycle: load_e=1, load_addr=(BASE_ADDR+index) mod 256, load_instr=assembled word; the write lands at that clock edge; then index+1; if index+1 == N -> CSUM (or DONE without the macro), else HI.
REQ-022 Address wraps 8'hFF -> 8'h00 silently; N=256 writes every location exactly once.
REQ-023 load_e=0 in every state other than WRITE; load_addr and load_instr hold their last values outside WRITE.
REQ-024 mem_e=1 at all times out of reset, so that both fetch and load are enabled.
REQ-025 busy=1 in COUNT, HI, LO, WRITE, CSUM.
REQ-026 start while busy is ignored.
REQ-027 abort (any state) -> IDLE on the same edge; no write occurs that cycle; done and error are cleared; abort wins over start and over a simultaneous byte transfer.
REQ-028 While byte_ready=1 and no transfer occurs for IDLE_TIMEOUT consecutive cycles (nonzero parameter) -> ERR.
REQ-029 DONE holds done=1 and ERR holds error=1 until the next start, abort, or reset.

Reset
REQ-030 rst_n=0 asynchronously forces state=IDLE, index=0, XOR=0, timeout counter=0, and byte_ready=load_e=busy=done=error=mem_e=0, load_addr=0, load_instr=0.
REQ-031 Reset mid-load leaves partially written memory as is; no further writes are issued.

Configuration
REQ-032 Macro PMEM_LOADER_CHECKSUM_EN defined: after the last WRITE, CSUM accepts one byte; if it equals the XOR of all accepted HI/LO bytes -> DONE, else -> ERR.
REQ-033 Macro undefined: CSUM state, XOR register and checksum byte are absent; the last WRITE -> DONE.

Structure
REQ-034 Shared package mc_pkg holds the state enum, PMEM_AW=8, INSTR_W=12, and BYTE_W=8.
REQ-035 One sub-module, pmem_loader_timeout (a loadable down-counter that raises an expiry flag), is natural; the FSM, index and assembly registers stay in pmem_loader.

Verification
REQ-036 start, bytes 02,0A,BC,01,23 (no macro) -> writes 0xABC@00 and 0x123@01, each with load_e high for one cycle, then done=1.
REQ-037 Same stream with the macro plus checksum byte 0x94 -> done=1; checksum 0x95 -> error=1, done=0.
REQ-038 BASE_ADDR=FE, N=3 -> writes at addresses FE, FF, 00.
REQ-039 HI byte 0x1A -> ERR, no load_e pulse; abort asserted during LO together with byte_valid -> IDLE, no write.
REQ-040 byte_valid held low for IDLE_TIMEOUT cycles in HI -> error=1; rst_n low mid-WRITE -> all outputs at reset values asynchronously.
